fib_lookup_arbiter: RTL and testbench

- Shares the single FIB longest-prefix-match lookup engine between NUM_REQ requesters (PIT / interface ports).
- Selects one pending request with round-robin priority and issues it to the FIB as a one-cycle start pulse.
- Waits for the FIB done strobe, then returns the matched prefix and length to the winning requester.
- A watchdog ends a hung lookup with a zero-length "no match" result.

---
 rtl/fib_lookup_arbiter.sv | 173 +++++++++++++++++
 tb/tb_fib_lookup_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_lookup_arbiter.sv
// Round-robin arbiter sharing one FIB longest-prefix-match engine between NUM_REQ requesters.
// A watchdog converts a hung lookup into a zero-length no-match response.
module fib_lookup_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 160
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [64*NUM_REQ-1:0] req_prefix,
   input  logic [6*NUM_REQ-1:0] req_len,
   output logic [NUM_REQ-1:0]   gnt,
   output logic                 fib_start,
   output logic [63:0]          fib_prefix,
   output logic [5:0]           fib_len,
   input  logic                 fib_done,
   input  logic [63:0]          fib_match_prefix,
   input  logic [5:0]           fib_match_len,
   output logic [NUM_REQ-1:0]   resp_valid,
   output logic [63:0]          resp_prefix,
   output logic [5:0]           resp_len,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CntW = 8;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [63:0]       lat_prefix_q, lat_prefix_d;
   logic [5:0]        lat_len_q, lat_len_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [63:0]       resp_prefix_q, resp_prefix_d;
   logic [5:0]        resp_len_q, resp_len_d;
   logic              tmo_q, tmo_d;

   logic              pick_found;
   logic [IdxW-1:0]   pick_idx;
   logic [IdxW:0]     cand;
   logic [63:0]       sel_prefix;
   logic [5:0]        sel_len;

   // Circular search starting at rr_ptr; cand never exceeds 2*NUM_REQ-2, so one subtract wraps it.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
         if (cand >= (IdxW+1)'(NUM_REQ)) begin
            cand = cand - (IdxW+1)'(NUM_REQ);
         end
         if (!pick_found && req[cand[IdxW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IdxW-1:0];
         end
      end
   end

   always_comb begin
      sel_prefix = '0;
      sel_len    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IdxW'(i)) begin
            sel_prefix = req_prefix[64*i +: 64];
            sel_len    = req_len[6*i +: 6];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      idx_d         = idx_q;
      lat_prefix_d  = lat_prefix_q;
      lat_len_d     = lat_len_q;
      cnt_d         = cnt_q;
      resp_prefix_d = resp_prefix_q;
      resp_len_d    = resp_len_q;
      tmo_d         = tmo_q;
      case (state_q)
         StIdle: begin
            if (pick_found) begin
               idx_d        = pick_idx;
               lat_prefix_d = sel_prefix;
               lat_len_d    = sel_len;
               state_d      = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            // A done strobe on the watchdog edge still delivers the real result.
            if (fib_done) begin
               resp_prefix_d = fib_match_prefix;
               resp_len_d    = fib_match_len;
               tmo_d         = 1'b0;
               state_d       = StResp;
            end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
               resp_prefix_d = lat_prefix_q;
               resp_len_d    = '0;
               tmo_d         = 1'b1;
               state_d       = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            rr_ptr_d = (idx_q == IdxW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            tmo_d    = 1'b0;
            state_d  = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         rr_ptr_q      <= '0;
         idx_q         <= '0;
         lat_prefix_q  <= '0;
         lat_len_q     <= '0;
         cnt_q         <= '0;
         resp_prefix_q <= '0;
         resp_len_q    <= '0;
         tmo_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         idx_q         <= idx_d;
         lat_prefix_q  <= lat_prefix_d;
         lat_len_q     <= lat_len_d;
         cnt_q         <= cnt_d;
         resp_prefix_q <= resp_prefix_d;
         resp_len_q    <= resp_len_d;
         tmo_q         <= tmo_d;
      end
   end

   always_comb begin
      gnt        = '0;
      resp_valid = '0;
      if (state_q == StIssue) begin
         gnt[idx_q] = 1'b1;
      end
      if (state_q == StResp) begin
         resp_valid[idx_q] = 1'b1;
      end
   end

   assign fib_start   = (state_q == StIssue);
   assign fib_prefix  = lat_prefix_q;
   assign fib_len     = lat_len_q;
   assign resp_prefix = resp_prefix_q;
   assign resp_len    = resp_len_q;
   assign busy        = (state_q != StIdle);
   assign timeout_err = (state_q == StResp) && tmo_q;

endmodule

// File: tb/tb_fib_lookup_arbiter.sv
// Scoreboard bench for fib_lookup_arbiter: a requester model, a FIB model with a
// configurable done delay, and a per-cycle monitor checking grants and responses.
module tb_fib_lookup_arbiter;

   localparam int unsigned N   = 4;
   localparam int unsigned TMO = 160;
   localparam logic [63:0] MatchMask = 64'hFFFF_0000_0000_0000;

   logic               clk = 1'b0;
   logic               rst;
   logic [N-1:0]       req;
   logic [64*N-1:0]    req_prefix;
   logic [6*N-1:0]     req_len;
   logic [N-1:0]       gnt;
   logic               fib_start;
   logic [63:0]        fib_prefix;
   logic [5:0]         fib_len;
   logic               fib_done;
   logic [63:0]        fib_match_prefix;
   logic [5:0]         fib_match_len;
   logic [N-1:0]       resp_valid;
   logic [63:0]        resp_prefix;
   logic [5:0]         resp_len;
   logic               busy;
   logic               timeout_err;

   fib_lookup_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .req              (req),
      .req_prefix       (req_prefix),
      .req_len          (req_len),
      .gnt              (gnt),
      .fib_start        (fib_start),
      .fib_prefix       (fib_prefix),
      .fib_len          (fib_len),
      .fib_done         (fib_done),
      .fib_match_prefix (fib_match_prefix),
      .fib_match_len    (fib_match_len),
      .resp_valid       (resp_valid),
      .resp_prefix      (resp_prefix),
      .resp_len         (resp_len),
      .busy             (busy),
      .timeout_err      (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned idx;
      logic [63:0] pfx;
      logic [5:0]  len;
      logic        tmo;
      int          lat;
   } exp_t;

   exp_t        resp_q[$];
   int unsigned gnt_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          cyc         = 0;
   int          fib_delay   = 0;   // 0: FIB never answers
   int          fib_cnt     = 0;
   int          start_cyc   = 0;
   logic [63:0] cur_mp;
   logic [5:0]  match_len;
   bit          spur_arm    = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [63:0] pfx_of(input int i);
      return req_prefix[64*i +: 64];
   endfunction

   function automatic logic [5:0] len_of(input int i);
      return req_len[6*i +: 6];
   endfunction

   task automatic tick();
      exp_t e;
      int   gi;
      @(negedge clk);
      cyc++;
      fib_done = 1'b0;
      if (fib_cnt > 0) begin
         fib_cnt--;
         if (fib_cnt == 0) begin
            fib_done         = 1'b1;
            fib_match_prefix = cur_mp;
            fib_match_len    = match_len;
         end
      end
      if (gnt != '0) begin
         if (gnt_q.size() == 0) begin
            check_val("unexpected_gnt", 64'(gnt), 64'd0);
         end else begin
            gi = int'(gnt_q.pop_front());
            check_val("gnt", 64'(gnt), 64'(1) << gi);
         end
         check_val("fib_start", 64'(fib_start), 64'd1);
         gi = 0;
         for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
         check_val("fib_prefix", fib_prefix, pfx_of(gi));
         check_val("fib_len", 64'(fib_len), 64'(len_of(gi)));
         req[gi] = 1'b0;
         e.idx = gi;
         if (fib_delay == 0 || fib_delay > int'(TMO)) begin
            e.pfx = pfx_of(gi);
            e.len = 6'd0;
            e.tmo = 1'b1;
            e.lat = TMO + 1;
         end else begin
            e.pfx = pfx_of(gi) ^ MatchMask;
            e.len = match_len;
            e.tmo = 1'b0;
            e.lat = fib_delay + 1;
         end
         resp_q.push_back(e);
         cur_mp    = pfx_of(gi) ^ MatchMask;
         fib_cnt   = fib_delay;
         start_cyc = cyc;
      end else begin
         check_val("fib_start_idle", 64'(fib_start), 64'd0);
      end
      if (resp_valid != '0) begin
         if (resp_q.size() == 0) begin
            check_val("unexpected_resp", 64'(resp_valid), 64'd0);
         end else begin
            e = resp_q.pop_front();
            check_val("resp_valid", 64'(resp_valid), 64'(1) << e.idx);
            check_val("resp_prefix", resp_prefix, e.pfx);
            check_val("resp_len", 64'(resp_len), 64'(e.len));
            check_val("timeout_err", 64'(timeout_err), 64'(e.tmo));
            check_val("latency", 64'(cyc - start_cyc), 64'(e.lat));
         end
         if (spur_arm) begin
            fib_done = 1'b1;
            spur_arm = 1'b0;
         end
      end else begin
         check_val("timeout_err_quiet", 64'(timeout_err), 64'd0);
      end
   endtask

   task automatic drain(input string tag, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (req == '0 && !busy && resp_q.size() == 0 && gnt_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check_val(tag, 64'(ok), 64'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_gnt"}, 64'(gnt), 64'd0);
      check_val({tag, "_fib_start"}, 64'(fib_start), 64'd0);
      check_val({tag, "_fib_prefix"}, fib_prefix, 64'd0);
      check_val({tag, "_fib_len"}, 64'(fib_len), 64'd0);
      check_val({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
      check_val({tag, "_resp_prefix"}, resp_prefix, 64'd0);
      check_val({tag, "_resp_len"}, 64'(resp_len), 64'd0);
      check_val({tag, "_busy"}, 64'(busy), 64'd0);
      check_val({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
   endtask

   initial begin
      bit seen;
      rst              = 1'b1;
      req              = '0;
      fib_done         = 1'b0;
      fib_match_prefix = '0;
      fib_match_len    = '0;
      match_len        = '0;
      cur_mp           = '0;
      for (int i = 0; i < N; i++) begin
         req_prefix[64*i +: 64] = 64'h0123_4567_89AB_C000 + 64'(i) * 64'h0000_0001_0000_0011;
         req_len[6*i +: 6]      = 6'(8 + 4 * i);
      end
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Contention: all four requesters at once, rr pointer at 0.
      fib_delay = 2;
      match_len = 6'd33;
      for (int i = 0; i < N; i++) gnt_q.push_back(i);
      req = 4'b1111;
      drain("drain_contention", 100);

      // Single request.
      req_prefix[63:0] = 64'hA5A5_0000_0000_1234;
      req_len[5:0]     = 6'd20;
      fib_delay        = 5;
      match_len        = 6'd12;
      gnt_q.push_back(0);
      req = 4'b0001;
      drain("drain_single", 50);
      check_val("busy_after_single", 64'(busy), 64'd0);

      // Fairness: serve 2, then 3 must beat 0.
      fib_delay = 3;
      match_len = 6'd7;
      gnt_q.push_back(2);
      req = 4'b0100;
      drain("drain_fair_a", 50);
      gnt_q.push_back(3);
      gnt_q.push_back(0);
      req = 4'b1001;
      drain("drain_fair_b", 50);

      // Watchdog: FIB never answers.
      fib_delay = 0;
      gnt_q.push_back(1);
      req = 4'b0010;
      drain("drain_timeout", 400);

      // Done on the watchdog edge wins.
      fib_delay = TMO;
      match_len = 6'd40;
      gnt_q.push_back(1);
      req = 4'b0010;
      drain("drain_timeout_edge", 400);

      // Reset three cycles after fib_start.
      fib_delay = 0;
      gnt_q.push_back(2);
      req  = 4'b0100;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick();
         seen = (gnt != '0);
      end
      check_val("reset_test_gnt_seen", 64'(seen), 64'd1);
      repeat (3) tick();
      rst = 1'b1;
      #1;
      check_all_zero("mid_reset");
      resp_q.delete();
      fib_cnt = 0;
      repeat (2) tick();
      rst = 1'b0;
      repeat (4) tick();
      fib_delay = 4;
      match_len = 6'd18;
      gnt_q.push_back(2);
      req = 4'b0100;
      drain("drain_after_reset", 50);

      // Spurious done in IDLE, then during RESP.
      fib_done = 1'b1;
      tick();
      check_val("spur_idle_busy", 64'(busy), 64'd0);
      tick();
      check_val("spur_idle_busy2", 64'(busy), 64'd0);
      fib_delay = 2;
      match_len = 6'd9;
      spur_arm  = 1'b1;
      gnt_q.push_back(0);
      req = 4'b0001;
      drain("drain_spur_resp", 50);
      repeat (3) tick();
      check_val("spur_resp_busy", 64'(busy), 64'd0);
      check_val("spur_resp_left", 64'(resp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
